uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
// - UART receiver control FSM with integrated edge/bit counter.
// - Detects start bit, sequences start, data, optional parity and stop bits, and enables the sampling, deserializer and checker stages.
// - Consumes the strt_glitch, par_err and stp_err flags and raises data_valid for clean frames only.
// - Sits between RX_IN/Prescale config and the data-sampling, deserializer, start/parity/stop-check stages.
// PARAMETERS
// - DATA_W      8   data bits per frame, LSB first
// - PRESCALE_W  6   width of Prescale and edge_cnt; legal Prescale values are 8, 16, 32
// - BIT_CNT_W   4   width of bit_cnt; must hold DATA_W+2
// PORTS
// - CLK          in   1           system clock (oversampling clock)
// - RST          in   1           asynchronous active-low reset
// - RX_IN        in   1           serial line, idle high
// - PAR_EN       in   1           1 = frame carries a parity bit
// - Prescale     in   PRESCALE_W  oversampling ratio P
// - strt_glitch  in   1           from start check; valid at edge_cnt==P-1 of bit 0
// - par_err      in   1           from parity check; valid at edge_cnt==P-1 of parity bit
// - stp_err      in   1           from stop check; valid at edge_cnt==P-1 of stop bit
// - edge_cnt     out  PRESCALE_W  oversample index within the current bit, 0..P-1
// - bit_cnt      out  BIT_CNT_W   bit index: 0 start, 1..DATA_W data, DATA_W+1 parity/stop
// - dat_samp_en  out  1           data-sampling enable; high in every non-IDLE state
// - deser_en     out  1           1-cycle pulse at edge_cnt==P-2 of each data bit
// - strt_chk_en  out  1           1-cycle pulse at edge_cnt==P-2 of bit 0
// - par_chk_en   out  1           1-cycle pulse at edge_cnt==P-2 of the parity bit
// - stp_chk_en   out  1           1-cycle pulse at edge_cnt==P-2 of the stop bit
// - data_valid   out  1           1-cycle pulse: frame received without errors
// - busy         out  1           high in every non-IDLE state
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; latched P and PAR_EN cleared. Reset mid-frame abandons the frame with no data_valid.
// - States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
// - IDLE: edge_cnt=0, bit_cnt=0. A cycle with RX_IN==0 is edge 0 of bit 0 (the detect cycle).
//   - In the detect cycle, latch Prescale and PAR_EN. Mid-frame changes are ignored.
//   - Next state is START; edge_cnt=1 in the first START cycle.
// - Counting: edge_cnt increments each cycle. At P-1 it wraps to 0 and bit_cnt increments.
//   - All state decisions happen in the cycle with edge_cnt==P-1.
// - START, at P-1: strt_glitch=1 -> IDLE (no deser_en ever issued); otherwise -> DATA.
// - DATA, at P-1 of bit DATA_W: -> PARITY if latched PAR_EN, otherwise -> STOP.
// - PARITY, at P-1: latch par_err into a sticky frame-error bit; always -> STOP.
// - STOP, at P-1: -> IDLE.
//   - data_valid=1 in the next cycle iff stp_err==0 and the sticky error is 0. The sticky error then clears.
// - Frame length N = DATA_W+2 (+1 with parity). data_valid and busy fall occur at cycle N*P, counting the detect cycle as 0.
// - RX_IN low in the first IDLE cycle after STOP starts the next frame (back-to-back frames are supported).
// - Checker pulses lead their flag sampling by one cycle, which matches the 1-cycle registered check stages.
// - Illegal Prescale values: behaviour undefined, with no lock-up. edge_cnt is compared with >= P-1 to force a wrap.
// - Unreachable state encodings -> IDLE.
// STRUCTURE
// - Shared package uart_rx_pkg:
//   - state encoding localparams (IDLE..STOP)
//   - PRESCALE_8/16/32 constants
//   - DATA_W default
// - Sub-module uart_rx_edge_bit_cnt:
//   - inputs: enable, latched P
//   - outputs: edge_cnt, bit_cnt, last_edge (edge_cnt==P-1), chk_edge (edge_cnt==P-2)
//   - synchronous clear when disabled
// - The FSM, latches and output registers stay in uart_rx_ctrl.
// TESTING
// - P=8, PAR_EN=0, frame 0xA5 clean:
//   - deser_en at cycles 14, 22, ..., 70
//   - stp_chk_en at cycle 78
//   - data_valid=1 only at cycle 80; busy low at cycle 80
// - P=16, PAR_EN=1, par_err=1 at parity edge 15:
//   - par_chk_en at cycle 158
//   - data_valid never asserted
//   - busy low at cycle 176
// - P=8, strt_glitch=1 at cycle 7: IDLE at cycle 8, no deser_en, no data_valid, next clean frame received normally.
// - P=8, PAR_EN=0, stp_err=1 at cycle 79: no data_valid; the following clean frame gives data_valid.
// - RST low at bit_cnt=4: all outputs 0 immediately; next frame gives data_valid at cycle 80.
// - Prescale changed 8->16 mid-frame: frame still completes at cycle 80; the next frame uses P=16 (data_valid at cycle 160).

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver control slice: state encodings,
// legal oversampling ratios and default frame geometry.
package uart_rx_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned PRESCALE_W_DEF = 6;
    localparam int unsigned BIT_CNT_W_DEF  = 4;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter for the UART receiver.
// last_edge flags the current cycle as edge P-1; chk_edge flags that the
// coming cycle will be edge P-2, so a registered pulse lands exactly on it.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
    parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  last_edge,
    output logic                  chk_edge
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    // >= forces a wrap even if an illegal ratio leaves the count above P-1
    always_comb begin
        last_edge = (edge_cnt_q >= PRESCALE_W'(prescale - PRESCALE_W'(1)));
    end

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!enable) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (last_edge) begin
            edge_cnt_d = '0;
            bit_cnt_d  = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
        end else begin
            edge_cnt_d = PRESCALE_W'(edge_cnt_q + PRESCALE_W'(1));
        end
    end

    always_comb begin
        chk_edge = enable && (edge_cnt_d == PRESCALE_W'(prescale - PRESCALE_W'(2)));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver control FSM: frames start/data/parity/stop bits, strobes the
// sampling and check stages, and flags clean frames with data_valid.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
    parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  busy
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  par_en_q, par_en_d;
    logic                  err_q, err_d;
    logic                  data_valid_q, data_valid_d;
    logic                  busy_q, busy_d;
    logic                  deser_en_q, deser_en_d;
    logic                  strt_chk_en_q, strt_chk_en_d;
    logic                  par_chk_en_q, par_chk_en_d;
    logic                  stp_chk_en_q, stp_chk_en_d;

    logic [PRESCALE_W-1:0] p_eff;
    logic                  cnt_en;
    logic                  last_edge;
    logic                  chk_edge;

    // The detect cycle already counts with the incoming ratio
    assign p_eff  = (state_q == ST_IDLE) ? Prescale : p_q;
    assign cnt_en = (state_d != ST_IDLE);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (cnt_en),
        .prescale  (p_eff),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge),
        .chk_edge  (chk_edge)
    );

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        par_en_d     = par_en_q;
        err_d        = err_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d  = ST_START;
                    p_d      = Prescale;
                    par_en_d = PAR_EN;
                    err_d    = 1'b0;
                end
            end
            ST_START: begin
                if (last_edge) begin
                    state_d = strt_glitch ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_edge && (bit_cnt == BIT_CNT_W'(DATA_W))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (last_edge) begin
                    err_d   = err_q | par_err;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (last_edge) begin
                    state_d      = ST_IDLE;
                    data_valid_d = !stp_err && !err_q;
                    err_d        = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes sit one cycle ahead of the flag sampling edge
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        deser_en_d    = chk_edge && (state_d == ST_DATA);
        strt_chk_en_d = chk_edge && (state_d == ST_START);
        par_chk_en_d  = chk_edge && (state_d == ST_PARITY);
        stp_chk_en_d  = chk_edge && (state_d == ST_STOP);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            p_q           <= '0;
            par_en_q      <= 1'b0;
            err_q         <= 1'b0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            deser_en_q    <= 1'b0;
            strt_chk_en_q <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            par_en_q      <= par_en_d;
            err_q         <= err_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            deser_en_q    <= deser_en_d;
            strt_chk_en_q <= strt_chk_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
        end
    end

    assign busy        = busy_q;
    assign dat_samp_en = busy_q;
    assign data_valid  = data_valid_q;
    assign deser_en    = deser_en_q;
    assign strt_chk_en = strt_chk_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: each frame pushes its expected strobe
// events into a scoreboard that is drained as the DUT raises them.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int unsigned PW = 6;
    localparam int unsigned BW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          busy;

    typedef struct {
        int         cyc;
        logic [4:0] mask;   // {data_valid, stp, par, strt, deser}
    } evt_t;

    evt_t sb[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_evt(input int cyc, input logic [4:0] mask, input int rst_cyc);
        evt_t e;
        e.cyc  = cyc;
        e.mask = mask;
        if (rst_cyc < 0 || cyc < rst_cyc) sb.push_back(e);
    endtask

    function automatic logic rx_bit(input int c, input int p, input logic pe, input logic [7:0] d);
        int b;
        b = c / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pe) return ^d;
        return 1'b1;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({edge_cnt, bit_cnt, busy, dat_samp_en, deser_en,
                    strt_chk_en, par_chk_en, stp_chk_en, data_valid});
    endfunction

    // One frame, cycle 0 being the detect cycle; inputs change at negedge.
    task automatic run_frame(input int p, input logic pe, input logic [7:0] d,
                             input logic glitch, input logic perr, input logic serr,
                             input int rst_cyc, input int pchg_cyc, input int pchg_val);
        int         n;
        int         endc;
        int         lim;
        logic [4:0] m;
        evt_t       e;
        n    = 10 + int'(pe);
        endc = glitch ? p : n * p;
        lim  = (rst_cyc >= 0) ? rst_cyc : endc + 3;

        push_evt(p - 2, 5'b00010, rst_cyc);
        if (!glitch) begin
            for (int b = 1; b <= 8; b++) push_evt(b * p + p - 2, 5'b00001, rst_cyc);
            if (pe) push_evt(9 * p + p - 2, 5'b00100, rst_cyc);
            push_evt((n - 1) * p + p - 2, 5'b01000, rst_cyc);
            if (!perr && !serr) push_evt(n * p, 5'b10000, rst_cyc);
        end

        for (int c = 0; c <= lim; c++) begin
            @(negedge CLK);
            if (c == rst_cyc) begin
                RST = 1'b0;
                #1;
                chk("reset_outputs", all_outs(), 32'h0);
                break;
            end
            m = {data_valid, stp_chk_en, par_chk_en, strt_chk_en, deser_en};
            if (m != 5'b0) begin
                if (sb.size() == 0) begin
                    chk("stray_pulse", 32'(m), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("evt_cycle", 32'(c), 32'(e.cyc));
                    chk("evt_kind", 32'(m), 32'(e.mask));
                end
            end
            if (c == 0) chk("busy_detect", 32'(busy), 32'h0);
            if (c == 1) chk("first_start", 32'({edge_cnt, busy, dat_samp_en}), 32'({PW'(1), 2'b11}));
            if (c == endc - 1) chk("busy_last", 32'(busy), 32'h1);
            if (c == endc) chk("busy_fall", 32'({busy, dat_samp_en}), 32'h0);
            if (!glitch && c == 3 * p + 2) chk("counters", 32'({bit_cnt, edge_cnt}), 32'({BW'(3), PW'(2)}));

            RX_IN       = (glitch && c > 0) ? 1'b1 : rx_bit(c, p, pe, d);
            PAR_EN      = pe;
            strt_glitch = glitch && (c == p - 1);
            par_err     = perr && (c == 10 * p - 1);
            stp_err     = serr && (c == n * p - 1);
            if (c == 0) Prescale = PW'(p);
            else if (c == pchg_cyc) Prescale = PW'(pchg_val);
        end
        chk("sb_empty", 32'(sb.size()), 32'h0);
        sb.delete();

        RX_IN       = 1'b1;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        if (rst_cyc >= 0) begin
            @(negedge CLK);
            RST = 1'b1;
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        RST         = 1'b0;
        RX_IN       = 1'b1;
        PAR_EN      = 1'b0;
        Prescale    = PW'(PRESCALE_8);
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_state", all_outs(), 32'h0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // clean frame, P=8, no parity
        run_frame(PRESCALE_8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        // parity error at P=16
        run_frame(PRESCALE_16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, -1, -1, 0);
        // start glitch, then a clean recovery frame
        run_frame(PRESCALE_8, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, -1, -1, 0);
        run_frame(PRESCALE_8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        // stop error, then a clean frame
        run_frame(PRESCALE_8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        run_frame(PRESCALE_8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        // reset in bit 4, then a clean frame
        run_frame(PRESCALE_8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 35, -1, 0);
        run_frame(PRESCALE_8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        // Prescale moves 8->16 mid-frame; next frame runs at 16
        run_frame(PRESCALE_8, 1'b0, 8'h6E, 1'b0, 1'b0, 1'b0, -1, 20, PRESCALE_16);
        run_frame(PRESCALE_16, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        // clean parity frame at P=32
        run_frame(PRESCALE_32, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
